hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TNEW_ALU, default 1: cycles after E-entry until an ALU result is forwardable.
REQ-002 Parameter TNEW_DM, default 2: cycles after E-entry until load data is forwardable.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tuse_rs  in  2  D-stage rs use time; 3 = not used.
REQ-006 tuse_rt  in  2  D-stage rt use time; 3 = not used.
REQ-007 res_d  in  3  D-stage result class: `alu, `pc, `dm, `other, `nw.
REQ-008 rs_d  in  5  D-stage rs index.
REQ-009 rt_d  in  5  D-stage rt index.
REQ-010 dst_d  in  5  D-stage destination index.
REQ-011 flush  in  1  exception/eret flush of E and M.
REQ-012 stall  out  1  freeze PC and D, bubble into E.
REQ-013 fwd_rs_d, fwd_rt_d  out  2 each  D-operand select: 0 regfile, 1 M, 2 W, 3 E.
REQ-014 fwd_rs_e, fwd_rt_e  out  2 each  E-operand select: 0 regfile, 1 M, 2 W.
REQ-015 fwd_rt_m  out  1  M store-data select: 0 pipeline, 1 W.

Function
REQ-016 Block SHALL hold tracking registers for E, M and W: dst (5b) and tnew (2b) per stage, plus rs/rt for E and rt for M.
REQ-017 On D->E advance, tnew_E SHALL load TNEW_ALU for `alu, TNEW_DM for `dm, 0 for `pc and `other; for `nw, dst_E SHALL load 0.
REQ-018 On E->M, tnew_M SHALL load tnew_E-1, saturating at 0; on M->W, W SHALL hold tnew 0.
REQ-019 stall SHALL be combinational: 1 iff, for X in {E,M}, dst_X!=0 and ((dst_X==rs_d and tnew_X>tuse_rs) or (dst_X==rt_d and tnew_X>tuse_rt)).
REQ-020 While stall=1, E SHALL load a bubble (dst=0, tnew=0, rs=rt=0); M and W SHALL advance normally.
REQ-021 Register index 0 SHALL never cause a stall or a non-zero forward select.
REQ-022 D-operand forward priority SHALL be E (only if tnew_E==0) > M (only if tnew_M==0) > W; no match -> 0.
REQ-023 E-operand forward priority SHALL be M (tnew_M==0) > W; fwd_rt_m SHALL be 1 iff dst_W!=0 and dst_W==rt_M.
REQ-024 Forward selects SHALL be combinational from current tracking registers; a select SHALL never point at a stage whose tnew>0.
REQ-025 flush=1 SHALL load bubbles into E and M at the next edge; W SHALL load old M contents; flush SHALL take priority over stall.
REQ-026 Simultaneous stall and matching W forward SHALL still drive the W select (the D operand is re-evaluated next cycle).

Reset
REQ-027 reset=1 SHALL clear all tracking registers to 0 at the edge, overriding flush and stall.
REQ-028 After reset, stall and all forward selects SHALL be 0 until a non-zero dst enters E.
REQ-029 Reset asserted mid-stall SHALL drop stall at the first edge with reset high.

Structure
REQ-030 Result-class codes (`alu, `pc, `dm, `other, `nw) and forward-select codes SHALL live in shared head.v.
REQ-031 One sub-module fwd_sel (5-bit operand index plus stage dst/tnew in, 2-bit select out) SHALL be instantiated once per forwarded operand.
REQ-032 Comparison/stall logic and stage registers SHALL reside in hazard_ctrl; no other sub-modules.

Verification
REQ-033 lw $8 then addu $9,$8,$8 -> stall=1 one cycle; after bubble, with addu in E and lw in W, fwd_rs_e=fwd_rt_e=2.
REQ-034 ori $9 then beq $9,$0 -> stall=1 one cycle; next cycle fwd_rs_d=1, stall=0.
REQ-035 jal then jr $31 -> stall=0, fwd_rs_d=3.
REQ-036 lw $8 then sw $8,0($4) (tuse_rt=2) -> stall=0; with sw in M, lw in W: fwd_rt_m=1.
REQ-037 ori $0 then addu $1,$0,$0 -> stall=0, all selects 0.
REQ-038 reset during lw-use stall -> stall=0 after the edge; flush with lw in E -> stall=0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared result-class and forward-select codes for the hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned TUSE_W = 2;
  localparam int unsigned RES_W  = 3;
  localparam int unsigned SEL_W  = 2;

  // D-stage result class: when (and whether) the instruction produces a value
  typedef enum logic [RES_W-1:0] {
    RES_ALU   = 3'd0,
    RES_PC    = 3'd1,
    RES_DM    = 3'd2,
    RES_OTHER = 3'd3,
    RES_NW    = 3'd4
  } res_e;

  // Operand source selects
  localparam logic [SEL_W-1:0] FWD_RF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_M  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_W  = 2'd2;
  localparam logic [SEL_W-1:0] FWD_E  = 2'd3;

  // Tracking payload held for the instruction in E
  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
  } e_stage_t;

  // Tracking payload held for the instruction in M
  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
    logic [REG_W-1:0]  rt;
  } m_stage_t;

  // Age a tnew value by one stage, saturating at zero
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : TNEW_W'(t - TNEW_W'(1));
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-source selector for one operand: newest ready stage wins.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]  idx_i,
  input  logic [REG_W-1:0]  dst_e_i,
  input  logic [TNEW_W-1:0] tnew_e_i,
  input  logic [REG_W-1:0]  dst_m_i,
  input  logic [TNEW_W-1:0] tnew_m_i,
  input  logic [REG_W-1:0]  dst_w_i,
  output logic [SEL_W-1:0]  sel_o
);

  // Priority E > M > W; a stage is only a source once its value exists; $0 never forwards
  always_comb begin
    sel_o = FWD_RF;
    if (idx_i != '0) begin
      if (dst_e_i == idx_i && tnew_e_i == '0) begin
        sel_o = FWD_E;
      end else if (dst_m_i == idx_i && tnew_m_i == '0) begin
        sel_o = FWD_M;
      end else if (dst_w_i == idx_i) begin
        sel_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall detection, forward selects, E/M/W tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TNEW_ALU = 1,
  parameter int unsigned TNEW_DM  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TUSE_W-1:0] tuse_rs,
  input  logic [TUSE_W-1:0] tuse_rt,
  input  logic [RES_W-1:0]  res_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic [REG_W-1:0]  dst_d,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_d,
  output logic [SEL_W-1:0]  fwd_rt_d,
  output logic [SEL_W-1:0]  fwd_rs_e,
  output logic [SEL_W-1:0]  fwd_rt_e,
  output logic              fwd_rt_m
);

  e_stage_t         e_q, e_d;
  m_stage_t         m_q, m_d;
  logic [REG_W-1:0] w_dst_q, w_dst_d;

  logic [TNEW_W-1:0] tnew_new;
  logic [REG_W-1:0]  dst_new;
  logic [SEL_W-1:0]  fwd_rt_m_sel;

  // A producer blocks a consumer when it cannot deliver by the consumer's use time
  function automatic logic blocks(input logic [REG_W-1:0]  dst,
                                  input logic [TNEW_W-1:0] tnew,
                                  input logic [REG_W-1:0]  idx,
                                  input logic [TUSE_W-1:0] tuse);
    return (dst != '0) && (dst == idx) && (tnew > tuse);
  endfunction

  // Stall on any unresolved dependence against E or M
  always_comb begin
    stall = blocks(e_q.dst, e_q.tnew, rs_d, tuse_rs) |
            blocks(e_q.dst, e_q.tnew, rt_d, tuse_rt) |
            blocks(m_q.dst, m_q.tnew, rs_d, tuse_rs) |
            blocks(m_q.dst, m_q.tnew, rt_d, tuse_rt);
  end

  // Decode D-stage result class into E-entry tracking values
  always_comb begin
    tnew_new = '0;
    dst_new  = dst_d;
    case (res_d)
      RES_ALU: tnew_new = TNEW_W'(TNEW_ALU);
      RES_DM:  tnew_new = TNEW_W'(TNEW_DM);
      RES_NW:  dst_new  = '0;
      default: tnew_new = '0;
    endcase
  end

  // Next-state for the stage registers: flush bubbles E and M, stall bubbles E
  always_comb begin
    e_d     = '{dst: dst_new, tnew: tnew_new, rs: rs_d, rt: rt_d};
    m_d     = '{dst: e_q.dst, tnew: tnew_dec(e_q.tnew), rt: e_q.rt};
    w_dst_d = m_q.dst;
    if (flush) begin
      e_d = '0;
      m_d = '0;
    end else if (stall) begin
      e_d = '0;
    end
  end

  // Stage tracking registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q     <= '0;
      m_q     <= '0;
      w_dst_q <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_dst_q <= w_dst_d;
    end
  end

  fwd_sel u_fwd_rs_d (
    .idx_i    (rs_d),
    .dst_e_i  (e_q.dst),
    .tnew_e_i (e_q.tnew),
    .dst_m_i  (m_q.dst),
    .tnew_m_i (m_q.tnew),
    .dst_w_i  (w_dst_q),
    .sel_o    (fwd_rs_d)
  );

  fwd_sel u_fwd_rt_d (
    .idx_i    (rt_d),
    .dst_e_i  (e_q.dst),
    .tnew_e_i (e_q.tnew),
    .dst_m_i  (m_q.dst),
    .tnew_m_i (m_q.tnew),
    .dst_w_i  (w_dst_q),
    .sel_o    (fwd_rt_d)
  );

  // E operands can only come from M or W, so the E source is tied off
  fwd_sel u_fwd_rs_e (
    .idx_i    (e_q.rs),
    .dst_e_i  ('0),
    .tnew_e_i ('0),
    .dst_m_i  (m_q.dst),
    .tnew_m_i (m_q.tnew),
    .dst_w_i  (w_dst_q),
    .sel_o    (fwd_rs_e)
  );

  fwd_sel u_fwd_rt_e (
    .idx_i    (e_q.rt),
    .dst_e_i  ('0),
    .tnew_e_i ('0),
    .dst_m_i  (m_q.dst),
    .tnew_m_i (m_q.tnew),
    .dst_w_i  (w_dst_q),
    .sel_o    (fwd_rt_e)
  );

  // M store data can only come from W
  fwd_sel u_fwd_rt_m (
    .idx_i    (m_q.rt),
    .dst_e_i  ('0),
    .tnew_e_i ('0),
    .dst_m_i  ('0),
    .tnew_m_i ('0),
    .dst_w_i  (w_dst_q),
    .sel_o    (fwd_rt_m_sel)
  );

  assign fwd_rt_m = (fwd_rt_m_sel == FWD_W);

endmodule
